hazard_fwd_ctrl: RTL

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_if.sv | 34 +++
 rtl/hazard_fwd_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle of the ID-stage hazard/forwarding signals between the pipeline and the control block.
// Latency: n/a (wires only); id_stall is combinational, selects and stall_count are registered.
// Backpressure: id_stall holds PC and IF/ID; flush kills the ID instruction.
// Ports: id_valid/id_rs/id_rt/id_dst/id_we/id_load/id_use_imm/flush from the pipeline,
//        id_stall/fwd_a_sel/fwd_b_sel/stall_count back to it.
interface hazard_fwd_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_we;
   logic              id_load;
   logic              id_use_imm;
   logic              flush;
   logic              id_stall;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_count;

   // pipeline side
   modport master (
      output id_valid, id_rs, id_rt, id_dst, id_we, id_load, id_use_imm, flush,
      input  id_stall, fwd_a_sel, fwd_b_sel, stall_count
   );

   // hazard/forwarding control side
   modport slave (
      input  id_valid, id_rs, id_rt, id_dst, id_we, id_load, id_use_imm, flush,
      output id_stall, fwd_a_sel, fwd_b_sel, stall_count
   );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall detection and EX operand forwarding selects for a 5-stage pipeline.
// Latency: id_stall combinational; fwd_*_sel registered, valid while the instruction sits in EX.
// Backpressure: id_stall holds PC/IF-ID for one cycle per load-use hazard; flush overrides it.
// Ports: clk, rst_n (synchronous, active-low), bus (hazard_fwd_ctrl_if.slave).
// Select encoding: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 immediate (B only).
// Optional macro HAZ_STALL_CNT_EN adds a saturating load-use stall counter on stall_count;
// without it stall_count is tied to zero.
module hazard_fwd_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_fwd_ctrl_if.slave    bus
);

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic              we;
      logic              load;
   } shadow_t;

   shadow_t    ex_q, mem_q, wb_q;
   shadow_t    ex_d;
   logic [1:0] a_sel_d, b_sel_d;
   logic [1:0] a_sel_q, b_sel_q;
   logic       ex_prod, mem_prod;
   logic       hazard;
   logic       stall;
   logic       bubble;

   // WB shadow is kept for completeness only: the register file is
   // write-through, so a WB producer is already visible to an ID read.
   logic       unused_wb;
   assign unused_wb = ^wb_q;

   always_comb begin
      // dst != 0 keeps register 0 out of both forwarding and stalling
      ex_prod  = ex_q.we  && (ex_q.dst  != '0);
      mem_prod = mem_q.we && (mem_q.dst != '0);

      hazard = bus.id_valid && ex_prod && ex_q.load &&
               ((bus.id_rs == ex_q.dst) ||
                (!bus.id_use_imm && (bus.id_rt == ex_q.dst)));

      // flush wins over the stall; reset forces the stall low
      stall  = rst_n && !bus.flush && hazard;
      bubble = bus.flush || hazard;

      // EX producer is the youngest, so it is checked first
      a_sel_d = 2'b00;
      if (ex_prod && (bus.id_rs == ex_q.dst))
         a_sel_d = 2'b01;
      else if (mem_prod && (bus.id_rs == mem_q.dst))
         a_sel_d = 2'b10;

      b_sel_d = 2'b00;
      if (bus.id_use_imm)
         b_sel_d = 2'b11;
      else if (ex_prod && (bus.id_rt == ex_q.dst))
         b_sel_d = 2'b01;
      else if (mem_prod && (bus.id_rt == mem_q.dst))
         b_sel_d = 2'b10;

      ex_d.dst  = bus.id_dst;
      ex_d.we   = bus.id_valid && bus.id_we;
      ex_d.load = bus.id_valid && bus.id_load;

      if (bubble) begin
         ex_d    = '0;
         a_sel_d = 2'b00;
         b_sel_d = 2'b00;
      end
   end

   // EX->MEM->WB advance every cycle; only EX entry is gated by stall/flush
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         a_sel_q <= 2'b00;
         b_sel_q <= 2'b00;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         a_sel_q <= a_sel_d;
         b_sel_q <= b_sel_d;
      end
   end

   assign bus.id_stall  = stall;
   assign bus.fwd_a_sel = a_sel_q;
   assign bus.fwd_b_sel = b_sel_q;

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // saturates at all-ones rather than wrapping
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (stall && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.stall_count = cnt_q;
`else
   assign bus.stall_count = '0;
`endif

endmodule
